// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DATA,
        OWN_FETCH,
        OWN_PREF
    } arb_owner_t;

    localparam int DEF_STARVE_MAX = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 7;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_DATA  = 0;
    localparam int GNT_FETCH = 1;
    localparam int GNT_PREF  = 2;

    // Map a one-hot grant onto the owner that will receive the response.
    function automatic arb_owner_t owner_of(input logic [2:0] gnt);
        arb_owner_t own;
        own = OWN_NONE;
        if (gnt[GNT_DATA]) begin
            own = OWN_DATA;
        end else if (gnt[GNT_FETCH]) begin
            own = OWN_FETCH;
        end else if (gnt[GNT_PREF]) begin
            own = OWN_PREF;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the port arbiter.
// slave: the arbiter's view. master: requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) ();
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;

    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;

    logic              p_req;
    logic [31:0]       p_addr;
    logic              p_gnt;
    logic              p_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, f_req, f_addr, p_req, p_addr, mem_rdata,
        output d_gnt, d_rvalid, f_gnt, f_rvalid, p_gnt, p_rvalid,
        output rdata, err, busy, mem_a, mem_we, mem_wdata
    );

    modport master (
        output d_req, d_we, d_addr, d_wdata, f_req, f_addr, p_req, p_addr, mem_rdata,
        input  d_gnt, d_rvalid, f_gnt, f_rvalid, p_gnt, p_rvalid,
        input  rdata, err, busy, mem_a, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: an aged PREF beats everything,
// otherwise DATA > FETCH > PREF. Output is one-hot or zero.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       d_req_i,
    input  logic       f_req_i,
    input  logic       p_req_i,
    input  logic       starve_i,
    output logic [2:0] gnt_o
);

    // Fixed priority with the starvation override checked first.
    always_comb begin
        gnt_o = '0;
        if (p_req_i && starve_i) begin
            gnt_o[GNT_PREF] = 1'b1;
        end else if (d_req_i) begin
            gnt_o[GNT_DATA] = 1'b1;
        end else if (f_req_i) begin
            gnt_o[GNT_FETCH] = 1'b1;
        end else if (p_req_i) begin
            gnt_o[GNT_PREF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between DATA, FETCH and PREF.
// Each access runs grant -> memory access -> response.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no access in flight; arbitrate, grant moves to ACCESS
//   ST_ACCESS | memory driven from latched request; rdata/err captured
//   ST_RESP   | owner's rvalid pulses; arbitrate again for back-to-back
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              oor_q, oor_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [SW-1:0]     starve_q, starve_d;
    logic              arb_en_q;

    logic              arb_slot;
    logic              starve_hit;
    logic [2:0]        gnt;
    logic [31:0]       sel_addr;
    logic              sel_oor;
    logic              unused_addr_lsb;

    // Grants are held off for one clock after reset release so no grant
    // can appear while reset is still being removed.
    assign arb_slot   = arb_en_q && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    assign starve_hit = (starve_q == SW'(STARVE_MAX));

    mem_arb_pick u_pick (
        .d_req_i  (bus.d_req && arb_slot),
        .f_req_i  (bus.f_req && arb_slot),
        .p_req_i  (bus.p_req && arb_slot),
        .starve_i (starve_hit),
        .gnt_o    (gnt)
    );

    // Address of the winning requester.
    always_comb begin
        sel_addr = bus.p_addr;
        if (gnt[GNT_DATA]) begin
            sel_addr = bus.d_addr;
        end else if (gnt[GNT_FETCH]) begin
            sel_addr = bus.f_addr;
        end
    end

    assign sel_oor         = |sel_addr[31:ADDR_W+2];
    assign unused_addr_lsb = ^sel_addr[1:0];

    // Next state and request latching; FETCH/PREF carry no write data so
    // the last DATA write data stays on mem_wdata.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        oor_d   = oor_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (|gnt) begin
                    state_d = ST_ACCESS;
                    owner_d = owner_of(gnt);
                    addr_d  = sel_addr[ADDR_W+1:2];
                    oor_d   = sel_oor;
                    we_d    = gnt[GNT_DATA] && bus.d_we;
                    if (gnt[GNT_DATA]) begin
                        wdata_d = bus.d_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // PREF aging: counts waiting cycles, saturates, clears on grant or drop.
    always_comb begin
        starve_d = '0;
        if (bus.p_req && !gnt[GNT_PREF]) begin
            starve_d = starve_hit ? starve_q : starve_q + SW'(1);
        end
    end

    // State, latched request and aging registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            addr_q   <= '0;
            oor_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            starve_q <= '0;
            arb_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            oor_q    <= oor_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            arb_en_q <= 1'b1;
        end
    end

    // Response capture at the end of ACCESS; writes and out-of-range return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            rdata_q <= (we_q || oor_q) ? '0 : bus.mem_rdata;
            err_q   <= oor_q;
        end
    end

    assign bus.d_gnt     = gnt[GNT_DATA];
    assign bus.f_gnt     = gnt[GNT_FETCH];
    assign bus.p_gnt     = gnt[GNT_PREF];
    assign bus.d_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign bus.f_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
    assign bus.p_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_PREF);
    assign bus.rdata     = rdata_q;
    assign bus.err       = (state_q == ST_RESP) && err_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.mem_a     = addr_q;
    assign bus.mem_we    = (state_q == ST_ACCESS) && we_q && !oor_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 7;
    localparam int STARVE_MAX = 8;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory attached to the arbiter.
    logic [31:0] mem [DEPTH];
    assign bus.mem_rdata = mem[bus.mem_a];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] = bus.mem_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t actual=0x%08h required=0x%08h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          who;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] ref_mem [DEPTH];
    bit          armed;
    int          arb_ok, starve, busy_until, we_cyc;
    logic [ADDR_W-1:0] m_a;
    logic [31:0] m_wd;
    bit          pw_valid;
    int          pw_cyc, pw_idx;
    logic [31:0] pw_data;
    logic [2:0]  eg, erv;
    logic [31:0] edata, ga;
    logic        eerr, goor, gwr;
    int          gwho;
    resp_t       r;

    // Every cycle: derive what the outputs must be, compare, then advance.
    always @(negedge clk) begin
        if (!rst_n) begin
            rq.delete();
            pw_valid   = 0;
            armed      = 0;
            arb_ok     = 0;
            starve     = 0;
            busy_until = -1;
            we_cyc     = -1;
            m_a        = '0;
            m_wd       = '0;
        end
        eg = '0;
        if (armed && cyc >= arb_ok) begin
            if (bus.p_req && starve >= STARVE_MAX) eg[2] = 1'b1;
            else if (bus.d_req) eg[0] = 1'b1;
            else if (bus.f_req) eg[1] = 1'b1;
            else if (bus.p_req) eg[2] = 1'b1;
        end
        erv = '0; edata = '0; eerr = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].who] = 1'b1;
            edata = rq[0].data;
            eerr  = rq[0].err;
        end
        check("m_gnt", {29'd0, bus.p_gnt, bus.f_gnt, bus.d_gnt}, {29'd0, eg});
        check("m_rvalid", {29'd0, bus.p_rvalid, bus.f_rvalid, bus.d_rvalid}, {29'd0, erv});
        check("m_err", {31'd0, bus.err}, {31'd0, eerr});
        if (erv != 0 || !rst_n) check("m_rdata", bus.rdata, edata);
        check("m_busy", {31'd0, bus.busy}, {31'd0, (cyc <= busy_until)});
        check("m_mem_we", {31'd0, bus.mem_we}, {31'd0, (cyc == we_cyc)});
        check("m_mem_a", {25'd0, bus.mem_a}, {25'd0, m_a});
        check("m_mem_wdata", bus.mem_wdata, m_wd);
        if (rst_n) begin
            if (erv != 0) void'(rq.pop_front());
            if (pw_valid && pw_cyc == cyc) begin
                ref_mem[pw_idx] = pw_data;
                pw_valid = 0;
            end
            if (eg != 0) begin
                gwho = eg[0] ? 0 : (eg[1] ? 1 : 2);
                ga   = (gwho == 0) ? bus.d_addr : ((gwho == 1) ? bus.f_addr : bus.p_addr);
                gwr  = (gwho == 0) && bus.d_we;
                goor = (ga >> (ADDR_W + 2)) != 0;
                m_a  = ga[ADDR_W+1:2];
                if (gwho == 0) m_wd = bus.d_wdata;
                busy_until = cyc + 2;
                arb_ok     = cyc + 2;
                r.due = cyc + 2;
                r.who = gwho;
                r.data = '0;
                r.err = goor;
                if (!goor && gwr) begin
                    pw_valid = 1;
                    pw_cyc   = cyc + 1;
                    pw_idx   = int'(ga[ADDR_W+1:2]);
                    pw_data  = bus.d_wdata;
                    we_cyc   = cyc + 1;
                end else if (!goor) begin
                    r.data = ref_mem[int'(ga[ADDR_W+1:2])];
                end
                rq.push_back(r);
            end
            if (bus.p_req && !eg[2]) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else starve = 0;
            armed = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.d_req = 0; bus.d_we = 0; bus.f_req = 0; bus.p_req = 0;
    endtask

    task automatic idle(input int n);
        drop_all();
        repeat (n) step();
    endtask

    // One isolated read by requester who (0 DATA, 1 FETCH, 2 PREF).
    task automatic single_read(input int who, input logic [31:0] addr,
                               input logic [31:0] exp_d, input logic exp_e, input string nm);
        logic [2:0] g;
        logic [2:0] v;
        step();
        case (who)
            0: begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = addr; end
            1: begin bus.f_req = 1; bus.f_addr = addr; end
            default: begin bus.p_req = 1; bus.p_addr = addr; end
        endcase
        @(negedge clk);
        g = {bus.p_gnt, bus.f_gnt, bus.d_gnt};
        check({nm, "_gnt"}, {29'd0, g}, 32'(1 << who));
        step();
        drop_all();
        step();
        @(negedge clk);
        v = {bus.p_rvalid, bus.f_rvalid, bus.d_rvalid};
        check({nm, "_rvalid"}, {29'd0, v}, 32'(1 << who));
        check({nm, "_rdata"}, bus.rdata, exp_d);
        check({nm, "_err"}, {31'd0, bus.err}, {31'd0, exp_e});
        idle(2);
    endtask

    int  pg[$];
    int  n_fg, n_fr, n_busy_lo;
    bit  nd, nf;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        mem[4]     = 32'h2010_0005;
        ref_mem[4] = 32'h2010_0005;
        drop_all();
        bus.d_addr = '0; bus.d_wdata = '0; bus.f_addr = '0; bus.p_addr = '0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mem_a", {25'd0, bus.mem_a}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        step();
        rst_n = 1;
        step();

        // Single FETCH read of word 4
        step();
        bus.f_req = 1; bus.f_addr = 32'h0000_0010;
        @(negedge clk);
        check("t1_fgnt", {31'd0, bus.f_gnt}, 32'd1);
        check("t1_busy_T", {31'd0, bus.busy}, 32'd0);
        step();
        bus.f_req = 0;
        @(negedge clk);
        check("t1_mem_a", {25'd0, bus.mem_a}, 32'd4);
        check("t1_busy_T1", {31'd0, bus.busy}, 32'd1);
        step();
        @(negedge clk);
        check("t1_frvalid", {31'd0, bus.f_rvalid}, 32'd1);
        check("t1_rdata", bus.rdata, 32'h2010_0005);
        check("t1_busy_T2", {31'd0, bus.busy}, 32'd1);
        idle(3);

        // DATA write and FETCH together; FETCH reads back the written word
        step();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF;
        bus.f_req = 1; bus.f_addr = 32'h20;
        @(negedge clk);
        check("t2_dgnt", {31'd0, bus.d_gnt}, 32'd1);
        check("t2_fgnt_lose", {31'd0, bus.f_gnt}, 32'd0);
        step();
        bus.d_req = 0; bus.d_we = 0;
        @(negedge clk);
        check("t2_mem_we", {31'd0, bus.mem_we}, 32'd1);
        check("t2_mem_a", {25'd0, bus.mem_a}, 32'd8);
        check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        check("t2_drvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("t2_fgnt", {31'd0, bus.f_gnt}, 32'd1);
        step();
        bus.f_req = 0;
        @(negedge clk);
        check("t2_mem_we_rd", {31'd0, bus.mem_we}, 32'd0);
        step();
        @(negedge clk);
        check("t2_frvalid", {31'd0, bus.f_rvalid}, 32'd1);
        check("t2_rdata", bus.rdata, 32'hDEAD_BEEF);
        idle(3);

        // Out-of-range DATA write
        step();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_0200; bus.d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t3_dgnt", {31'd0, bus.d_gnt}, 32'd1);
        step();
        drop_all();
        @(negedge clk);
        check("t3_mem_we", {31'd0, bus.mem_we}, 32'd0);
        step();
        @(negedge clk);
        check("t3_drvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("t3_err", {31'd0, bus.err}, 32'd1);
        check("t3_rdata", bus.rdata, 32'd0);
        idle(2);
        check("t3_mem0", mem[0], 32'hA500_0000);

        // Isolated reads: requester, address, expected data, expected err
        single_read(0, 32'h0000_0008, 32'hA500_0002, 1'b0, "rd_data");
        single_read(2, 32'h0000_0013, 32'h2010_0005, 1'b0, "rd_pref_lsb");
        single_read(1, 32'h8000_0000, 32'h0000_0000, 1'b1, "rd_fetch_oor");
        single_read(2, 32'h0000_01FC, 32'hA500_007F, 1'b0, "rd_pref_top");

        // PREF aging with DATA/FETCH alternating
        step();
        bus.p_req = 1; bus.p_addr = 32'h0C;
        bus.d_req = 1; bus.d_addr = 32'h04; bus.f_req = 0; bus.f_addr = 32'h08;
        nd = 1; nf = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.p_gnt) pg.push_back(k);
            if (bus.d_gnt) begin nd = 0; nf = 1; end
            else if (bus.f_gnt) begin nd = 1; nf = 0; end
            step();
            bus.d_req = nd; bus.f_req = nf;
        end
        drop_all();
        check("t4_pgnt_count", 32'(pg.size()), 32'd2);
        if (pg.size() >= 2) begin
            check("t4_pgnt_first", 32'(pg[0]), 32'd8);
            check("t4_pgnt_second", 32'(pg[1]), 32'd18);
        end
        idle(4);

        // Back-to-back FETCH with f_req held
        step();
        bus.f_req = 1; bus.f_addr = 32'h14;
        n_fg = 0; n_fr = 0; n_busy_lo = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.f_gnt) n_fg++;
            if (bus.f_rvalid) n_fr++;
            if (k > 0 && !bus.busy) n_busy_lo++;
            step();
        end
        drop_all();
        check("t5_fgnt_count", 32'(n_fg), 32'd6);
        check("t5_frvalid_count", 32'(n_fr), 32'd5);
        check("t5_busy_low", 32'(n_busy_lo), 32'd0);
        idle(4);

        // Reset during the ACCESS of a DATA write
        step();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h30; bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        check("t6_dgnt", {31'd0, bus.d_gnt}, 32'd1);
        step();
        check("t6_mem_we_pre", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 0;
        #1;
        check("t6_mem_we_drop", {31'd0, bus.mem_we}, 32'd0);
        check("t6_busy_drop", {31'd0, bus.busy}, 32'd0);
        step();
        @(negedge clk);
        check("t6_no_drvalid", {31'd0, bus.d_rvalid}, 32'd0);
        step();
        rst_n = 1;
        @(negedge clk);
        check("t6_no_gnt_release", {31'd0, bus.d_gnt}, 32'd0);
        check("t6_mem12_kept", mem[12], 32'hA500_000C);
        step();
        @(negedge clk);
        check("t6_regrant", {31'd0, bus.d_gnt}, 32'd1);
        step();
        drop_all();
        @(negedge clk);
        check("t6_mem_we", {31'd0, bus.mem_we}, 32'd1);
        step();
        @(negedge clk);
        check("t6_drvalid", {31'd0, bus.d_rvalid}, 32'd1);
        check("t6_err", {31'd0, bus.err}, 32'd0);
        step();
        check("t6_mem12_written", mem[12], 32'h1234_5678);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle MIPS core between three requesters: data load/store (DATA), instruction fetch (FETCH) and the prefetch reader (PREF).
- Sits between the control unit / prefetch logic and the memory.
- Sequences each access as grant → memory access → response, with fixed priority plus anti-starvation aging for PREF.

Parameters:
- DATA_W, 32, memory word width.
- ADDR_W, 7, word-address width to the memory; depth = 2**ADDR_W = 128 words.
- STARVE_MAX, 8, number of cycles PREF may wait before it is promoted to top priority.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_req  in  1  DATA request.
- d_we  in  1  DATA write when 1, read when 0.
- d_addr  in  32  DATA byte address.
- d_wdata  in  DATA_W  DATA write data.
- d_gnt  out  1  DATA request accepted (1-cycle pulse).
- d_rvalid  out  1  DATA response/ack (1-cycle pulse).
- f_req  in  1  FETCH read request.
- f_addr  in  32  FETCH byte address.
- f_gnt  out  1  FETCH accepted.
- f_rvalid  out  1  FETCH response.
- p_req  in  1  PREF read request.
- p_addr  in  32  PREF byte address.
- p_gnt  out  1  PREF accepted.
- p_rvalid  out  1  PREF response.
- rdata  out  DATA_W  response data, shared; qualified by the owner's rvalid.
- err  out  1  out-of-range access; coincident with rvalid.
- busy  out  1  high whenever state is not IDLE.
- mem_a  out  ADDR_W  word address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.

Behaviour:
- Requester contract: hold req and payload stable until gnt. Payload is captured on the gnt cycle and may change on the following cycle. Drop or re-assert req after gnt for a new access.
- FSM states:
  - IDLE: arbitrate; if any req, pulse the winner's gnt, latch owner, addr, we and wdata, then go to ACCESS.
  - ACCESS: drive mem_a, mem_we and mem_wdata from the latched values; register rdata and err at the clock edge; go to RESP.
  - RESP: pulse owner's rvalid; arbitrate again exactly as in IDLE. Go to ACCESS on a grant, otherwise to IDLE.
- Latency: gnt → rvalid = 2 cycles. Peak throughput is one access per 2 cycles.
- Priority at each arbitration:
  - If the starve counter equals STARVE_MAX and p_req=1: PREF wins.
  - Otherwise DATA > FETCH > PREF.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Increments each cycle that p_req=1 and p_gnt=0, saturating at STARVE_MAX.
  - Clears on p_gnt or when p_req=0.
- Address mapping: word index = addr[ADDR_W+1:2]; addr[1:0] are ignored (no misalignment fault).
- Out of range: if addr[31:ADDR_W+2] != 0, then in ACCESS force mem_we=0, register rdata=0 and err=1. The response is still delivered normally.
- Writes: rvalid acts as the write ack; rdata=0 and err=0 unless out of range.
- mem_a and mem_wdata hold their last values outside ACCESS; mem_we=1 only in ACCESS.
- At most one gnt and at most one rvalid are high in any cycle. In RESP, a new gnt may coincide with the previous owner's rvalid.
- Simultaneous requests: only the winner is granted. Losers keep req asserted and compete at the next arbitration.
- Reset (async, any state): state=IDLE; all gnt, rvalid, err, mem_we and busy = 0; rdata=0; mem_a=0; mem_wdata=0; starve counter=0; owner=none. An in-flight access is dropped without a response, and a write in ACCESS is cancelled. Requesters still holding req are re-granted after reset is released.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum {ST_IDLE, ST_ACCESS, ST_RESP} arb_state_t
  - typedef enum {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_PREF} arb_owner_t
  - localparam DEF_STARVE_MAX=8
- One sub-module, mem_arb_pick: combinational priority/aging selector. Inputs are the three req lines and a starve flag; output is a one-hot grant.

Test Plan:
- Single FETCH read, f_addr=0x0000_0010, mem word[4]=0x2010_0005 → f_gnt at cycle T, mem_a=4 at T+1, f_rvalid with rdata=0x2010_0005 at T+2; busy high T+1..T+2.
- d_req and f_req asserted together, DATA write d_addr=0x20, d_wdata=0xDEAD_BEEF → d_gnt first, mem_we=1 with mem_a=8 for one cycle. f_gnt coincides with d_rvalid. Subsequent FETCH of 0x20 returns 0xDEAD_BEEF.
- p_req held while d_req and f_req alternate continuously → p_gnt at the first arbitration after the starve counter hits 8. Counter returns to 0 after p_gnt.
- DATA write to d_addr=0x0000_0200 (word 128, out of range) → mem_we stays 0, d_rvalid with err=1 and rdata=0; memory unchanged.
- rst_n pulsed low during ACCESS of a DATA write → mem_we drops immediately, no d_rvalid. After release with d_req still high: d_gnt one cycle later, followed by normal completion.
- Back-to-back FETCH reads with f_req held → f_gnt every 2 cycles, f_rvalid every 2 cycles, state never returns to IDLE.
